dnoc_l2_rd_arb: RTL and testbench
=================================

DNOC_L2_RD_ARB -- requirements
Module: dnoc_l2_rd_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of L2 dmem read requesters; index 0 is the core-read path.
REQ-002 SHALL have parameter OSTD_DEPTH, default 4 (power of 2), maximum number of granted reads still waiting for data.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port req_rd_req, input, NUM_REQ, per-requester read request.
REQ-006 SHALL have port req_rd_gnt, output, NUM_REQ, per-requester grant, at most one bit high.
REQ-007 SHALL have port req_rd_addr, input, NUM_REQ x 13, per-requester read address.
REQ-008 SHALL have port req_rd_valid, output, NUM_REQ, per-requester return-data valid.
REQ-009 SHALL have port req_rd_data, output, 256, return data broadcast to all requesters.
REQ-010 SHALL have port req_rd_ready, input, NUM_REQ, per-requester return-data ready.
REQ-011 SHALL have ports L2_dmem_rd_req (out, 1), L2_dmem_rd_gnt (in, 1), L2_dmem_rd_addr (out, 13), L2_dmem_rd_valid (in, 1), L2_dmem_rd_data (in, 256), L2_dmem_rd_ready (out, 1), the shared L2 read port.
REQ-012 SHALL have port ostd_cnt, output, log2(OSTD_DEPTH)+1, number of outstanding reads.
REQ-013 SHALL have port err_orphan, output, 1, sticky error flag.

Function
REQ-014 SHALL select a winner combinationally among the asserted req_rd_req bits by round-robin, starting the search at rr_ptr.
REQ-015 SHALL drive L2_dmem_rd_req = (|req_rd_req) & ~id_fifo_full, and L2_dmem_rd_addr = the winner's address.
REQ-016 SHALL drive req_rd_gnt[winner] = L2_dmem_rd_gnt & L2_dmem_rd_req, with all other grant bits 0.
REQ-017 SHALL, on each request handshake (req & gnt), push the winner index into the ID FIFO (OSTD_DEPTH entries) and load rr_ptr with (winner+1) mod NUM_REQ on the next edge.
REQ-018 SHALL drive req_rd_valid[head_id] = L2_dmem_rd_valid while the ID FIFO is non-empty, with all other valid bits 0; req_rd_data = L2_dmem_rd_data.
REQ-019 SHALL drive L2_dmem_rd_ready = req_rd_ready[head_id] when the FIFO is non-empty, else 0.
REQ-020 SHALL pop the FIFO head on L2_dmem_rd_valid & L2_dmem_rd_ready; return data stays in grant order.
REQ-021 SHALL allow a push and a pop in the same cycle when the FIFO is not full, leaving ostd_cnt unchanged.
REQ-022 SHALL block new requests while the FIFO is full, even if a pop occurs in the same cycle.
REQ-023 SHALL set err_orphan when L2_dmem_rd_valid is asserted while the FIFO is empty, hold it until reset, and route no data for that beat.
REQ-024 SHALL keep the grant latency at 0 cycles (combinational) and the data routing at 0 cycles; the block adds no data register.
REQ-025 SHALL leave rr_ptr unchanged when the winner's request is not granted, and SHALL keep the winner stable while L2_dmem_rd_gnt is low and the requests are unchanged.

Reset
REQ-026 SHALL, on rst_n low, clear rr_ptr, the FIFO pointers, ostd_cnt and err_orphan to 0 asynchronously.
REQ-027 SHALL drive all grant, valid and ready outputs to 0 during reset.
REQ-028 SHALL discard in-flight reads when reset is asserted mid-operation; any later orphan valid sets err_orphan.

Configuration
REQ-029 SHALL support macro DNOC_L2_RD_ARB_CORE_PRIO_EN: when defined, requester 0 wins whenever req_rd_req[0] is high, and round-robin applies only among requesters 1..NUM_REQ-1 when bit 0 is low; when undefined, pure round-robin over all requesters.

Verification
REQ-030 SHALL cover: req_rd_req=3'b111 held with gnt=1 -> grants rotate 0,1,2,0 and ostd_cnt rises to 3.
REQ-031 SHALL cover: 4 grants with no returned valid (OSTD_DEPTH=4) -> L2_dmem_rd_req=0 on the 5th request; one pop -> request re-enabled next cycle.
REQ-032 SHALL cover: grants to 2 then 0, data D1 and D2 returned -> req_rd_valid[2] with D1, then req_rd_valid[0] with D2; req_rd_ready[2]=0 stalls L2_dmem_rd_ready.
REQ-033 SHALL cover: L2_dmem_rd_valid=1 with an empty FIFO -> err_orphan=1 and sticky until rst_n low.
REQ-034 SHALL cover: with DNOC_L2_RD_ARB_CORE_PRIO_EN defined, req=3'b111 for 3 grants -> all three go to requester 0; without the macro -> 0,1,2.
REQ-035 SHALL cover: rst_n asserted with ostd_cnt=2 -> ostd_cnt=0 and all grant/valid/ready outputs 0 immediately.

Source files
------------

// File: rtl/dnoc_l2_rd_arb_if.sv
// Bundle of requester-side and L2-side read signals for the L2 dmem read arbiter.
// slave = arbiter view, master = requesters plus L2 port view.
interface dnoc_l2_rd_arb_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]       req_rd_req;
  logic [NUM_REQ-1:0]       req_rd_gnt;
  logic [NUM_REQ-1:0][12:0] req_rd_addr;
  logic [NUM_REQ-1:0]       req_rd_valid;
  logic [255:0]             req_rd_data;
  logic [NUM_REQ-1:0]       req_rd_ready;

  logic                     L2_dmem_rd_req;
  logic                     L2_dmem_rd_gnt;
  logic [12:0]              L2_dmem_rd_addr;
  logic                     L2_dmem_rd_valid;
  logic [255:0]             L2_dmem_rd_data;
  logic                     L2_dmem_rd_ready;

  modport slave (
    input  req_rd_req, req_rd_addr, req_rd_ready,
           L2_dmem_rd_gnt, L2_dmem_rd_valid, L2_dmem_rd_data,
    output req_rd_gnt, req_rd_valid, req_rd_data,
           L2_dmem_rd_req, L2_dmem_rd_addr, L2_dmem_rd_ready
  );

  modport master (
    output req_rd_req, req_rd_addr, req_rd_ready,
           L2_dmem_rd_gnt, L2_dmem_rd_valid, L2_dmem_rd_data,
    input  req_rd_gnt, req_rd_valid, req_rd_data,
           L2_dmem_rd_req, L2_dmem_rd_addr, L2_dmem_rd_ready
  );
endinterface

// File: rtl/dnoc_l2_rd_arb.sv
// Round-robin arbiter sharing one L2 dmem read port; an ID FIFO routes returns in grant order.
// Optional macro DNOC_L2_RD_ARB_CORE_PRIO_EN gives requester 0 absolute priority.
module dnoc_l2_rd_arb #(
  parameter int NUM_REQ    = 3,
  parameter int OSTD_DEPTH = 4,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int PW  = (OSTD_DEPTH > 1) ? $clog2(OSTD_DEPTH) : 1,
  localparam int CW  = $clog2(OSTD_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dnoc_l2_rd_arb_if.slave      bus,
  output logic [CW-1:0]        ostd_cnt,
  output logic                 err_orphan
);

  logic [IDW-1:0] r_rr_ptr;
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_cnt;
  logic           r_err;
  logic [IDW-1:0] r_id_mem [OSTD_DEPTH];

  logic [IDW-1:0]     w_win;
  logic               w_found;
  logic [NUM_REQ-1:0] w_cand;
  logic [IDW-1:0]     w_head;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_orphan;

  function automatic logic [IDW-1:0] f_wrap(input int v);
    return IDW'(v % NUM_REQ);
  endfunction

  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    w_cand  = bus.req_rd_req;
`ifdef DNOC_L2_RD_ARB_CORE_PRIO_EN
    if (bus.req_rd_req[0]) begin
      w_win   = '0;
      w_found = 1'b1;
    end
    w_cand[0] = 1'b0;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && w_cand[f_wrap(int'(r_rr_ptr) + i)]) begin
        w_win   = f_wrap(int'(r_rr_ptr) + i);
        w_found = 1'b1;
      end
    end
  end

  assign w_full   = (r_cnt == CW'(OSTD_DEPTH));
  assign w_empty  = (r_cnt == '0);
  assign w_head   = r_id_mem[r_rd_ptr];
  assign w_push   = bus.L2_dmem_rd_req & bus.L2_dmem_rd_gnt;
  assign w_pop    = bus.L2_dmem_rd_valid & bus.L2_dmem_rd_ready;
  assign w_orphan = bus.L2_dmem_rd_valid & w_empty;

  // Outputs are gated by rst_n so they read 0 for the whole reset window.
  assign bus.L2_dmem_rd_req   = rst_n & (|bus.req_rd_req) & ~w_full;
  assign bus.L2_dmem_rd_addr  = bus.req_rd_addr[w_win];
  assign bus.L2_dmem_rd_ready = rst_n & ~w_empty & bus.req_rd_ready[w_head];
  assign bus.req_rd_data      = bus.L2_dmem_rd_data;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_route
      assign bus.req_rd_gnt[gi]   = w_push & (w_win == IDW'(gi));
      assign bus.req_rd_valid[gi] = rst_n & ~w_empty & bus.L2_dmem_rd_valid &
                                    (w_head == IDW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_id_mem[r_wr_ptr] <= w_win;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) begin
        r_rr_ptr <= f_wrap(int'(w_win) + 1);
        r_wr_ptr <= (r_wr_ptr == PW'(OSTD_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PW'(OSTD_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (w_orphan) begin
        r_err <= 1'b1;
      end
    end
  end

  assign ostd_cnt   = r_cnt;
  assign err_orphan = r_err;

endmodule

// File: tb/tb_dnoc_l2_rd_arb.sv
// Directed bench for dnoc_l2_rd_arb: rotation, full blocking, ordered return, orphan and reset.
module tb_dnoc_l2_rd_arb;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] ostd_cnt;
  logic       err_orphan;

  always #5 clk = ~clk;

  dnoc_l2_rd_arb_if #(.NUM_REQ(3)) bus ();

  dnoc_l2_rd_arb #(.NUM_REQ(3), .OSTD_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .ostd_cnt   (ostd_cnt),
    .err_orphan (err_orphan)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end else begin
      $display("ok   %s value=%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [255:0] d1;
  logic [255:0] d2;
  logic [2:0]   exp_g [4];
  int           exp_hd [4];
  int           exp_w;
  logic [2:0]   one_hot;

  initial begin
    d1 = {8{32'hD1D1_0001}};
    d2 = {8{32'hD2D2_0002}};
`ifdef DNOC_L2_RD_ARB_CORE_PRIO_EN
    exp_g  = '{3'b001, 3'b001, 3'b001, 3'b001};
    exp_hd = '{0, 0, 0, 0};
    exp_w  = 0;
`else
    exp_g  = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_hd = '{0, 1, 2, 0};
    exp_w  = 1;
`endif
    for (int i = 0; i < 3; i++) bus.req_rd_addr[i] = 13'h100 + 13'(i);
    bus.L2_dmem_rd_data = '0;

    // Reset with every input active: outputs must stay quiet.
    bus.req_rd_req = 3'b111;
    bus.req_rd_ready = 3'b111;
    bus.L2_dmem_rd_gnt = 1'b1;
    bus.L2_dmem_rd_valid = 1'b1;
    #12;
    chk("rst_gnt", 256'(bus.req_rd_gnt), 256'(3'b000));
    chk("rst_valid", 256'(bus.req_rd_valid), 256'(3'b000));
    chk("rst_l2_ready", 256'(bus.L2_dmem_rd_ready), 256'(1'b0));
    chk("rst_cnt", 256'(ostd_cnt), 256'(3'd0));
    chk("rst_err", 256'(err_orphan), 256'(1'b0));
    tick();
    rst_n = 1'b1;
    bus.L2_dmem_rd_valid = 1'b0;

    // Four grants with all requests held; no return data.
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr_gnt%0d", k), 256'(bus.req_rd_gnt), 256'(exp_g[k]));
      chk($sformatf("rr_addr%0d", k), 256'(bus.L2_dmem_rd_addr), 256'(13'h100 + 13'(exp_hd[k])));
      chk($sformatf("rr_cnt%0d", k), 256'(ostd_cnt), 256'(k));
      tick();
    end
    #1;
    chk("full_l2_req", 256'(bus.L2_dmem_rd_req), 256'(1'b0));
    chk("full_gnt", 256'(bus.req_rd_gnt), 256'(3'b000));
    chk("full_cnt", 256'(ostd_cnt), 256'(3'd4));

    // Pop while full: request stays blocked this cycle.
    bus.L2_dmem_rd_valid = 1'b1;
    bus.L2_dmem_rd_data = d1;
    #1;
    one_hot = 3'b001 << exp_hd[0];
    chk("pop0_valid", 256'(bus.req_rd_valid), 256'(one_hot));
    chk("pop0_data", bus.req_rd_data, d1);
    chk("pop0_l2_ready", 256'(bus.L2_dmem_rd_ready), 256'(1'b1));
    chk("pop0_l2_req", 256'(bus.L2_dmem_rd_req), 256'(1'b0));
    tick();
    bus.L2_dmem_rd_valid = 1'b0;
    bus.L2_dmem_rd_gnt = 1'b0;
    #1;
    chk("reen_cnt", 256'(ostd_cnt), 256'(3'd3));
    chk("reen_l2_req", 256'(bus.L2_dmem_rd_req), 256'(1'b1));
    chk("reen_gnt", 256'(bus.req_rd_gnt), 256'(3'b000));
    chk("reen_addr", 256'(bus.L2_dmem_rd_addr), 256'(13'h100 + 13'(exp_w)));
    tick();
    chk("hold_addr", 256'(bus.L2_dmem_rd_addr), 256'(13'h100 + 13'(exp_w)));
    chk("hold_cnt", 256'(ostd_cnt), 256'(3'd3));

    // Drain the rest, first with the head requester stalled.
    bus.req_rd_req = 3'b000;
    bus.L2_dmem_rd_valid = 1'b1;
    bus.L2_dmem_rd_data = d2;
    one_hot = 3'b001 << exp_hd[1];
    bus.req_rd_ready = ~one_hot;
    #1;
    chk("stall_l2_ready", 256'(bus.L2_dmem_rd_ready), 256'(1'b0));
    chk("stall_valid", 256'(bus.req_rd_valid), 256'(one_hot));
    tick();
    chk("stall_cnt", 256'(ostd_cnt), 256'(3'd3));
    bus.req_rd_ready = 3'b111;
    for (int k = 1; k < 4; k++) begin
      #1;
      one_hot = 3'b001 << exp_hd[k];
      chk($sformatf("drain_valid%0d", k), 256'(bus.req_rd_valid), 256'(one_hot));
      chk($sformatf("drain_l2_ready%0d", k), 256'(bus.L2_dmem_rd_ready), 256'(1'b1));
      tick();
    end
    bus.L2_dmem_rd_valid = 1'b0;
    #1;
    chk("drain_cnt", 256'(ostd_cnt), 256'(3'd0));
    chk("drain_err", 256'(err_orphan), 256'(1'b0));

    // Grants to 2 then 0; returns routed in that order.
    bus.L2_dmem_rd_gnt = 1'b1;
    bus.req_rd_req = 3'b100;
    #1;
    chk("ord_gnt2", 256'(bus.req_rd_gnt), 256'(3'b100));
    tick();
    bus.req_rd_req = 3'b001;
    #1;
    chk("ord_gnt0", 256'(bus.req_rd_gnt), 256'(3'b001));
    tick();
    bus.req_rd_req = 3'b000;
    bus.L2_dmem_rd_gnt = 1'b0;
    #1;
    chk("ord_cnt", 256'(ostd_cnt), 256'(3'd2));
    bus.L2_dmem_rd_valid = 1'b1;
    bus.L2_dmem_rd_data = d1;
    bus.req_rd_ready = 3'b011;
    #1;
    chk("ord_d1_valid", 256'(bus.req_rd_valid), 256'(3'b100));
    chk("ord_d1_data", bus.req_rd_data, d1);
    chk("ord_d1_stall", 256'(bus.L2_dmem_rd_ready), 256'(1'b0));
    tick();
    chk("ord_stall_cnt", 256'(ostd_cnt), 256'(3'd2));
    bus.req_rd_ready = 3'b111;
    #1;
    chk("ord_d1_ready", 256'(bus.L2_dmem_rd_ready), 256'(1'b1));
    tick();
    bus.L2_dmem_rd_data = d2;
    #1;
    chk("ord_d2_valid", 256'(bus.req_rd_valid), 256'(3'b001));
    chk("ord_d2_data", bus.req_rd_data, d2);
    tick();
    bus.L2_dmem_rd_valid = 1'b0;
    #1;
    chk("ord_end_cnt", 256'(ostd_cnt), 256'(3'd0));

    // Reset mid-operation with two reads in flight.
    bus.req_rd_req = 3'b110;
    bus.L2_dmem_rd_gnt = 1'b1;
    tick();
    tick();
    bus.req_rd_req = 3'b000;
    bus.L2_dmem_rd_gnt = 1'b0;
    #1;
    chk("inflight_cnt", 256'(ostd_cnt), 256'(3'd2));
    rst_n = 1'b0;
    bus.req_rd_req = 3'b111;
    bus.L2_dmem_rd_gnt = 1'b1;
    bus.L2_dmem_rd_valid = 1'b1;
    #1;
    chk("arst_cnt", 256'(ostd_cnt), 256'(3'd0));
    chk("arst_gnt", 256'(bus.req_rd_gnt), 256'(3'b000));
    chk("arst_valid", 256'(bus.req_rd_valid), 256'(3'b000));
    chk("arst_l2_ready", 256'(bus.L2_dmem_rd_ready), 256'(1'b0));
    tick();
    rst_n = 1'b1;
    bus.req_rd_req = 3'b000;
    bus.L2_dmem_rd_gnt = 1'b0;
    bus.L2_dmem_rd_valid = 1'b0;
    #1;
    chk("post_rst_err", 256'(err_orphan), 256'(1'b0));

    // Orphan return after the discarded reads.
    bus.L2_dmem_rd_valid = 1'b1;
    bus.L2_dmem_rd_data = d1;
    #1;
    chk("orphan_valid", 256'(bus.req_rd_valid), 256'(3'b000));
    chk("orphan_l2_ready", 256'(bus.L2_dmem_rd_ready), 256'(1'b0));
    tick();
    bus.L2_dmem_rd_valid = 1'b0;
    #1;
    chk("orphan_set", 256'(err_orphan), 256'(1'b1));
    tick();
    tick();
    chk("orphan_sticky", 256'(err_orphan), 256'(1'b1));
    chk("orphan_cnt", 256'(ostd_cnt), 256'(3'd0));
    rst_n = 1'b0;
    #1;
    chk("orphan_clr", 256'(err_orphan), 256'(1'b0));
    tick();
    rst_n = 1'b1;
    tick();
    chk("orphan_clr_hold", 256'(err_orphan), 256'(1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
